// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> EXEC -> WB around a registered ALU and a register file.
// Optional build macro ALU_SEQ_R0_ZERO_EN makes register 0 read-only (writes to rd==0 are suppressed).
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        op_s;
  logic [REG_AW-1:0] rd_s, rs_s, rt_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic              wb_write_s;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

  function automatic logic op_writes(input logic [2:0] op);
    return (op != 3'b000) && !op_is_illegal(op);
  endfunction

  assign op_s      = instr_q[15:13];
  assign rd_s      = instr_q[12:10];
  assign rs_s      = instr_q[9:7];
  assign rt_s      = instr_q[6:4];
  assign imm_ext_s = {{(DATA_W-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

`ifdef ALU_SEQ_R0_ZERO_EN
  assign wb_write_s = op_writes(op_s) && (rd_s != 3'd0);
`else
  assign wb_write_s = op_writes(op_s);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= 16'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // rst gates the WB strobes so an instruction caught by reset in WB never retires
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    alu_opcode  = 3'b000;
    alu_a       = '0;
    alu_b       = '0;
    alu_imm     = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = op_writes(instr[15:13]) ? S_EXEC : S_WB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rf_raddr_a = rs_s;
        rf_raddr_b = rt_s;
        alu_opcode = op_s;
        alu_a      = rf_rdata_a;
        alu_b      = rf_rdata_b;
        alu_imm    = imm_ext_s;
        state_d    = S_WB;
      end
      S_WB: begin
        done    = !rst;
        illegal = !rst && op_is_illegal(op_s);
        rf_we   = !rst && wb_write_s;
        if (op_writes(op_s)) begin
          rf_waddr = rd_s;
          rf_wdata = alu_result;
        end else begin
          rf_waddr = '0;
          rf_wdata = '0;
        end
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and registered ALU.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr, alu_opcode;
  logic [15:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_imm, alu_result, rf_wdata, retired_cnt;
  logic        rf_we, done, illegal;

  logic [15:0] rf [8];
  logic        tb_we;
  logic [2:0]  tb_waddr;
  logic [15:0] tb_wdata;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done), .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (tb_we) rf[tb_waddr] <= tb_wdata;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // ALU: MUL scales operand A by the immediate
  always @(posedge clk) begin
    case (alu_opcode)
      3'b001:  alu_result <= alu_a + alu_b;
      3'b010:  alu_result <= alu_a + alu_imm;
      3'b011:  alu_result <= alu_a - alu_b;
      3'b100:  alu_result <= alu_a - alu_imm;
      3'b101:  alu_result <= alu_a * alu_imm;
      default: alu_result <= 16'd0;
    endcase
  end

  function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] mk_i(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [6:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_load(input logic [2:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = 16'd0; tb_we = 1'b0; tb_waddr = 3'd0; tb_wdata = 16'd0;
    step(); step();
    rst = 1'b0;
    #1;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    n_tests++; if ({rf_we, done, illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {rf_we, done, illegal}); end
    n_tests++; if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
    n_tests++; if ({alu_opcode, alu_a, alu_b, alu_imm, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata} !== 73'd0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero address/data outputs op=%b a=%h waddr=%0d wdata=%h", alu_opcode, alu_a, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_reset_abort();
    rf_load(3'd1, 16'd5); rf_load(3'd2, 16'd7); rf_load(3'd3, 16'd0);
    instr_valid = 1'b1; instr = mk_r(3'b001, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    n_tests++; if (alu_opcode !== 3'b001) begin n_fail++; $display("FAIL abort_exec_op: got %b want 001", alu_opcode); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if ({rf_we, done} !== 2'b00) begin n_fail++; $display("FAIL abort_exec_strobes: got %b want 00", {rf_we, done}); end
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_exec_ready: got %b want 1", instr_ready); end
    step();
    n_tests++; if (rf[3] !== 16'd0) begin n_fail++; $display("FAIL abort_exec_rf: got %h want 0000", rf[3]); end
    n_tests++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL abort_exec_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    // NOP goes straight to WB; reset held there must suppress done
    instr_valid = 1'b1; instr = 16'd0;
    step();
    instr_valid = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_wb_done: got %b want 0", done); end
    step();
    rst = 1'b0;
    step();
    n_tests++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL abort_wb_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_add();
    instr_valid = 1'b1; instr = mk_r(3'b001, 3'd3, 3'd1, 3'd2);
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready0: got %b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_ready1: got %b want 0", instr_ready); end
    n_tests++; if ({rf_raddr_a, rf_raddr_b, alu_a, alu_b} !== {3'd1, 3'd2, 16'd5, 16'd7}) begin
      n_fail++; $display("FAIL add_exec: got ra=%0d rb=%0d a=%0d b=%0d want 1 2 5 7", rf_raddr_a, rf_raddr_b, alu_a, alu_b);
    end
    step();
    n_tests++; if ({rf_we, rf_waddr, rf_wdata, done} !== {1'b1, 3'd3, 16'd12, 1'b1}) begin
      n_fail++; $display("FAIL add_wb: got we=%b waddr=%0d wdata=%0d done=%b want 1 3 12 1", rf_we, rf_waddr, rf_wdata, done);
    end
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_ready2: got %b want 0", instr_ready); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tests++; if ({done, instr_ready, retired_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL add_retire: got done=%b ready=%b cnt=%0d want 0 1 %0d", done, instr_ready, retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_imm();
    rf_load(3'd1, 16'd10);
    instr_valid = 1'b1; instr = mk_i(3'b100, 3'd4, 3'd1, 7'h7F);
    step();
    instr_valid = 1'b0;
    n_tests++; if (alu_imm !== 16'hFFFF) begin n_fail++; $display("FAIL subi_imm: got %h want ffff", alu_imm); end
    step();
    n_tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd4, 16'd11}) begin
      n_fail++; $display("FAIL subi_wb: got we=%b waddr=%0d wdata=%h want 1 4 000b", rf_we, rf_waddr, rf_wdata);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    rf_load(3'd1, 16'hFFFD);
    instr_valid = 1'b1; instr = mk_i(3'b101, 3'd5, 3'd1, 7'd5);
    step();
    instr_valid = 1'b0;
    n_tests++; if ({alu_opcode, alu_imm} !== {3'b101, 16'd5}) begin n_fail++; $display("FAIL mul_exec: got op=%b imm=%h want 101 0005", alu_opcode, alu_imm); end
    step();
    n_tests++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 16'hFFF1}) begin
      n_fail++; $display("FAIL mul_wb: got we=%b waddr=%0d wdata=%h want 1 5 fff1", rf_we, rf_waddr, rf_wdata);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tests++; if (rf[5] !== 16'hFFF1) begin n_fail++; $display("FAIL mul_rf: got %h want fff1", rf[5]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    int acc [3];
    int k = 0;
    prog[0] = mk_r(3'b001, 3'd6, 3'd2, 3'd2);
    prog[1] = mk_i(3'b010, 3'd7, 3'd6, 7'd1);
    prog[2] = mk_r(3'b011, 3'd6, 3'd7, 3'd2);
    instr_valid = 1'b1; instr = prog[0];
    for (int c = 0; c < 20 && k < 3; c++) begin
      if (instr_ready) begin
        acc[k] = c;
        step();
        k++;
        if (k < 3) instr = prog[k]; else instr_valid = 1'b0;
      end else begin
        step();
      end
    end
    instr_valid = 1'b0;
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", k); end
    else begin
      n_tests++; if (acc[1] - acc[0] !== 3) begin n_fail++; $display("FAIL b2b_gap1: got %0d want 3", acc[1] - acc[0]); end
      n_tests++; if (acc[2] - acc[1] !== 3) begin n_fail++; $display("FAIL b2b_gap2: got %0d want 3", acc[2] - acc[1]); end
    end
    step(); step();
    exp_cnt = exp_cnt + 16'd3;
    n_tests++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    n_tests++; if ({rf[6], rf[7]} !== {16'd8, 16'd15}) begin n_fail++; $display("FAIL b2b_rf: got r6=%0d r7=%0d want 8 15", rf[6], rf[7]); end
  endtask

  task automatic test_illegal_nop();
    instr_valid = 1'b1; instr = mk_r(3'b111, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    n_tests++; if ({done, illegal, rf_we} !== 3'b110) begin n_fail++; $display("FAIL illegal_wb: got done/illegal/we=%b want 110", {done, illegal, rf_we}); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tests++; if ({done, illegal, instr_ready, retired_cnt} !== {3'b001, exp_cnt}) begin
      n_fail++; $display("FAIL illegal_after: got done=%b illegal=%b ready=%b cnt=%0d want 0 0 1 %0d", done, illegal, instr_ready, retired_cnt, exp_cnt);
    end
    n_tests++; if (rf[3] !== 16'd12) begin n_fail++; $display("FAIL illegal_rf: got %0d want 12", rf[3]); end
    instr_valid = 1'b1; instr = mk_r(3'b110, 3'd2, 3'd0, 3'd0);
    step();
    instr_valid = 1'b0;
    n_tests++; if ({done, illegal, rf_we} !== 3'b110) begin n_fail++; $display("FAIL illegal110_wb: got %b want 110", {done, illegal, rf_we}); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    instr_valid = 1'b1; instr = mk_r(3'b000, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    n_tests++; if ({done, illegal, rf_we} !== 3'b100) begin n_fail++; $display("FAIL nop_wb: got %b want 100", {done, illegal, rf_we}); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tests++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL nop_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_r0();
    rf_load(3'd1, 16'd4);
    instr_valid = 1'b1; instr = mk_i(3'b010, 3'd0, 3'd1, 7'd3);
    step();
    instr_valid = 1'b0;
    step();
`ifdef ALU_SEQ_R0_ZERO_EN
    n_tests++; if ({done, rf_we} !== 2'b10) begin n_fail++; $display("FAIL r0_wb: got done/we=%b want 10", {done, rf_we}); end
`else
    n_tests++; if ({done, rf_we, rf_waddr, rf_wdata} !== {2'b11, 3'd0, 16'd7}) begin
      n_fail++; $display("FAIL r0_wb: got done=%b we=%b waddr=%0d wdata=%0d want 1 1 0 7", done, rf_we, rf_waddr, rf_wdata);
    end
`endif
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_tests++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL r0_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_add();
    test_imm();
    test_back_to_back();
    test_illegal_nop();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
